clk_div_multi: RTL and testbench

- Parametrised multi-channel clock divider. It is the successor to the fixed cascaded divide-by-2 stages that generate the processor and regfile clocks.
- Produces NUM_CH independent divided clocks from one source clock. Each channel has a runtime-programmable half-period and an output inversion option.
- Ratio changes are glitch-free and take effect only at a period boundary. A resync input phase-aligns all channels.
- Sits at the top level beside the memories; drives imem/dmem/regfile/processor clock domains plus per-channel edge ticks.

---
 rtl/clk_div_multi.sv | 139 +++++++++++++
 tb/tb_clk_div_multi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel divides the source clock by 2*H, where H is a runtime half-period
// (0 gates the channel). Ratio and inversion changes are shadowed and applied only
// at the high-to-low phase boundary so no output pulse is shorter than the
// shorter of the old and new half-periods. A resync pulse restarts all channels in phase.
module clk_div_multi #(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       DIV_W     = 8,
  parameter int unsigned       RESET_DIV = 2,
  parameter logic [NUM_CH-1:0] RESET_INV = '0
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         cfg_wr,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                             cfg_div,
  input  logic                                         cfg_inv,
  input  logic                                         resync,
  output logic [NUM_CH-1:0]                            clk_out,
  output logic [NUM_CH-1:0]                            rise_tick,
  output logic [NUM_CH-1:0]                            fall_tick,
  output logic [NUM_CH-1:0]                            pending
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Out-of-range channel selects are dropped entirely.
  logic ch_valid;
  assign ch_valid = (32'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q, div_d;
    logic             inv_q, inv_d;
    logic [DIV_W-1:0] sdiv_q, sdiv_d;
    logic             sinv_q, sinv_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             clk_q, clk_d;
    logic             rise_q, fall_q;
    logic             wr_hit;
    logic             wrap;

    assign wr_hit = cfg_wr && ch_valid && (cfg_ch == CH_W'(i));

    // Next-state: counting, shadow capture and the three ways a shadow gets applied.
    always_comb begin
      div_d   = div_q;
      inv_d   = inv_q;
      sdiv_d  = sdiv_q;
      sinv_d  = sinv_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      wrap    = 1'b0;
      if (resync) begin
        // A write in the resync cycle takes precedence over an older shadow.
        if (wr_hit) begin
          div_d = cfg_div;
          inv_d = cfg_inv;
        end else if (pend_q) begin
          div_d = sdiv_q;
          inv_d = sinv_q;
        end
        pend_d  = 1'b0;
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (div_q == '0) begin
        // Gated: no boundary will ever come, so apply a pending shadow right away.
        cnt_d   = '0;
        phase_d = 1'b0;
        if (pend_q) begin
          div_d  = sdiv_q;
          inv_d  = sinv_q;
          pend_d = 1'b0;
        end
        if (wr_hit) begin
          sdiv_d = cfg_div;
          sinv_d = cfg_inv;
          pend_d = 1'b1;
        end
      end else begin
        wrap = (cnt_q == (div_q - DIV_W'(1)));
        if (wrap) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          // High-to-low toggle is the only safe point to change ratio.
          if (phase_q && pend_q) begin
            div_d  = sdiv_q;
            inv_d  = sinv_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        // Same-cycle write lands in the shadow for the following boundary.
        if (wr_hit) begin
          sdiv_d = cfg_div;
          sinv_d = cfg_inv;
          pend_d = 1'b1;
        end
      end
      clk_d = phase_d ^ inv_d;
    end

    // Channel state, output clock flop and edge ticks.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        div_q   <= DIV_W'(RESET_DIV);
        inv_q   <= RESET_INV[i];
        sdiv_q  <= '0;
        sinv_q  <= 1'b0;
        pend_q  <= 1'b0;
        cnt_q   <= '0;
        phase_q <= 1'b0;
        clk_q   <= RESET_INV[i];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        div_q   <= div_d;
        inv_q   <= inv_d;
        sdiv_q  <= sdiv_d;
        sinv_q  <= sinv_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
        clk_q   <= clk_d;
        rise_q  <= clk_d & ~clk_q;
        fall_q  <= ~clk_d & clk_q;
      end
    end

    assign clk_out[i]   = clk_q;
    assign rise_tick[i] = rise_q;
    assign fall_tick[i] = fall_q;
    assign pending[i]   = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi.
// Cycle n is the state sampled 1 time unit after the n-th rising edge following reset release.
module tb_clk_div_multi;

  logic       clock;
  logic       reset;
  logic       cfg_wr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_inv;
  logic       resync;
  logic [3:0] clk_out, rise_tick, fall_tick, pending;

  // Second instance with 6 channels so an out-of-range select (7) is expressible.
  logic       cfg_wr6;
  logic [2:0] cfg_ch6;
  logic       resync6;
  logic [5:0] clk_out6, rise_tick6, fall_tick6, pending6;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  clk_div_multi u_dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_inv   (cfg_inv),
    .resync    (resync),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .pending   (pending)
  );

  clk_div_multi #(
    .NUM_CH (6)
  ) u_dut6 (
    .clock     (clock),
    .reset     (reset),
    .cfg_wr    (cfg_wr6),
    .cfg_ch    (cfg_ch6),
    .cfg_div   (cfg_div),
    .cfg_inv   (cfg_inv),
    .resync    (resync6),
    .clk_out   (clk_out6),
    .rise_tick (rise_tick6),
    .fall_tick (fall_tick6),
    .pending   (pending6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to cycle n (bounded: the clock is free-running).
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] dv, input logic iv);
    cfg_wr  = 1'b1;
    cfg_ch  = ch;
    cfg_div = dv;
    cfg_inv = iv;
  endtask

  initial begin
    reset   = 1'b0;
    cfg_wr  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    cfg_inv = 1'b0;
    resync  = 1'b0;
    cfg_wr6 = 1'b0;
    cfg_ch6 = '0;
    resync6 = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_clk", clk_out, 4'h0);
    chk("rst_pend", pending, 4'h0);
    chk("rst_rise", rise_tick, 4'h0);
    chk("rst_fall", fall_tick, 4'h0);
    reset = 1'b1;
    cyc   = 0;

    // Defaults: H=2 everywhere, aligned.
    go(1);  chk("c1_clk", clk_out, 4'h0);
    go(2);  chk("c2_clk", clk_out, 4'hf);
            chk("c2_rise", rise_tick, 4'hf);
            chk("c2_fall", fall_tick, 4'h0);
    go(3);  chk("c3_clk", clk_out, 4'hf);
            chk("c3_rise", rise_tick, 4'h0);
    go(4);  chk("c4_clk", clk_out, 4'h0);
            chk("c4_fall", fall_tick, 4'hf);

    // Ch1 -> H=3 while high; out-of-range write on the 6-channel instance.
    go(6);  wr(2'd1, 8'd3, 1'b0);
            cfg_wr6 = 1'b1;
            cfg_ch6 = 3'd7;
    go(7);  cfg_wr = 1'b0; cfg_wr6 = 1'b0;
            chk("c7_pend", pending, 4'b0010);
            chk("c7_clk", clk_out, 4'hf);
            chk("c7_pend6", pending6, 6'h00);
            chk("c7_clk6", clk_out6, 6'h3f);
    go(8);  chk("c8_pend", pending, 4'h0);
            chk("c8_clk", clk_out, 4'h0);
            chk("c8_fall", fall_tick, 4'hf);
            chk("c8_clk6", clk_out6, 6'h00);
            chk("c8_pend6", pending6, 6'h00);
    go(10); chk("c10_clk", clk_out, 4'b1101);
    go(11); chk("c11_clk", clk_out, 4'b1111);
            chk("c11_rise", rise_tick, 4'b0010);
    go(12); chk("c12_clk", clk_out, 4'b0010);
            chk("c12_fall", fall_tick, 4'b1101);

    // Ch2 -> gated (H=0) at its next boundary.
    go(14); chk("c14_clk", clk_out, 4'b1101);
            chk("c14_rise", rise_tick, 4'b1101);
            chk("c14_fall", fall_tick, 4'b0010);
            wr(2'd2, 8'd0, 1'b0);
    go(15); cfg_wr = 1'b0;
            chk("c15_pend", pending, 4'b0100);
    go(16); chk("c16_pend", pending, 4'h0);
            chk("c16_clk", clk_out, 4'b0000);
            chk("c16_fall", fall_tick, 4'b1101);
    go(18); chk("c18_clk", clk_out, 4'b1011);
            chk("c18_rise", rise_tick, 4'b1001);
            wr(2'd2, 8'd1, 1'b1);
    go(19); cfg_wr = 1'b0;
            chk("c19_pend", pending, 4'b0100);
            chk("c19_clk2", clk_out[2], 1'b0);
    go(20); chk("c20_pend", pending, 4'h0);
            chk("c20_clk", clk_out, 4'b0100);
            chk("c20_rise", rise_tick, 4'b0100);
            chk("c20_fall", fall_tick, 4'b1011);
    go(21); chk("c21_clk2", clk_out[2], 1'b0);
            chk("c21_fall2", fall_tick[2], 1'b1);

    // Ch3 pending H=2 inv=1, then resync with a same-cycle write of ch2 H=5.
    go(22); chk("c22_clk2", clk_out[2], 1'b1);
            wr(2'd3, 8'd2, 1'b1);
    go(23); chk("c23_pend", pending, 4'b1000);
            wr(2'd2, 8'd5, 1'b0);
            resync = 1'b1;
    go(24); cfg_wr = 1'b0; resync = 1'b0;
            chk("c24_clk", clk_out, 4'b1000);
            chk("c24_pend", pending, 4'h0);
            chk("c24_rise", rise_tick, 4'h0);
            chk("c24_fall", fall_tick, 4'b0011);
    go(25); chk("c25_clk", clk_out, 4'b1000);
            chk("c25_pend", pending, 4'h0);
            chk("c25_rise", rise_tick, 4'h0);
    go(26); chk("c26_clk", clk_out, 4'b0001);
            chk("c26_rise", rise_tick, 4'b0001);
            chk("c26_fall", fall_tick, 4'b1000);
    go(27); chk("c27_clk", clk_out, 4'b0011);
            chk("c27_rise", rise_tick, 4'b0010);
    go(29); chk("c29_clk", clk_out, 4'b1110);
            chk("c29_rise", rise_tick, 4'b0100);

    // Back-to-back writes to ch0: last (H=6) wins.
            wr(2'd0, 8'd4, 1'b0);
    go(30); chk("c30_clk0", clk_out[0], 1'b1);
            chk("c30_pend0", pending[0], 1'b1);
            wr(2'd0, 8'd6, 1'b0);
    go(31); cfg_wr = 1'b0;
            chk("c31_pend0", pending[0], 1'b1);
    go(32); chk("c32_pend0", pending[0], 1'b0);
            chk("c32_clk0", clk_out[0], 1'b0);
            chk("c32_fall0", fall_tick[0], 1'b1);
    go(36); chk("c36_clk0", clk_out[0], 1'b0);
    go(37); chk("c37_clk0", clk_out[0], 1'b0);
    go(38); chk("c38_clk0", clk_out[0], 1'b1);
            chk("c38_rise0", rise_tick[0], 1'b1);

    // Reset mid-period with a pending config.
            wr(2'd1, 8'd4, 1'b0);
    go(39); cfg_wr = 1'b0;
            chk("c39_pend1", pending[1], 1'b1);
            reset = 1'b0;
            #1;
            chk("mrst_clk", clk_out, 4'h0);
            chk("mrst_pend", pending, 4'h0);
            chk("mrst_rise", rise_tick, 4'h0);
            chk("mrst_fall", fall_tick, 4'h0);
            chk("mrst_clk6", clk_out6, 6'h00);
            @(posedge clock);
            #1;
            reset = 1'b1;
            cyc   = 0;
    go(1);  chk("r1_clk", clk_out, 4'h0);
            chk("r1_pend", pending, 4'h0);
    go(2);  chk("r2_clk", clk_out, 4'hf);
            chk("r2_rise", rise_tick, 4'hf);
    go(4);  chk("r4_clk", clk_out, 4'h0);
            chk("r4_fall", fall_tick, 4'hf);
    go(6);  chk("r6_clk", clk_out, 4'hf);
            chk("r6_clk6", clk_out6, 6'h3f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
